// File: rtl/benes_cfg_scheduler_if.sv
// Config-push, word-launch and network-control bundle shared by the Benes
// scheduler (slave side) and whatever feeds it (master side).
interface benes_cfg_scheduler_if #(
   parameter int N_STAGES = 5,
   parameter int SW_W     = 4,
   parameter int CNT_W    = 16
);
   logic                          cfg_valid;
   logic                          cfg_ready;
   logic [N_STAGES*SW_W-1:0]      cfg_data;
   logic [CNT_W-1:0]              cfg_count;
   logic                          in_valid;
   logic                          in_ready;
   logic                          net_valid;
   logic [0:N_STAGES-1][SW_W-1:0] switch_set;
   logic                          out_valid;
   logic                          busy;

   modport master (
      output cfg_valid, cfg_data, cfg_count, in_valid,
      input  cfg_ready, in_ready, net_valid, switch_set, out_valid, busy
   );

   modport slave (
      input  cfg_valid, cfg_data, cfg_count, in_valid,
      output cfg_ready, in_ready, net_valid, switch_set, out_valid, busy
   );
endinterface

// File: rtl/benes_cfg_scheduler.sv
// Config queue, launch gating and per-stage skewed switch settings for an
// 8-port pipelined Benes network. Optional counters: define BENES_CFG_STATS_EN.
module benes_cfg_scheduler #(
   parameter int N_STAGES  = 5,
   parameter int SW_W      = 4,
   parameter int STAGE_LAT = 2,
   parameter int OUT_LAT   = 9,
   parameter int CFG_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   benes_cfg_scheduler_if.slave bus
`ifdef BENES_CFG_STATS_EN
   ,
   output logic [31:0]          stat_words,
   output logic [15:0]          stat_cfgs
`endif
);
   localparam int              CFG_W   = N_STAGES * SW_W;
   localparam int              PTR_W   = $clog2(CFG_DEPTH);
   localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(CFG_DEPTH);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   state_t           state_nxt;

   logic [CFG_W-1:0] fifo_data [0:CFG_DEPTH-1];
   logic [CNT_W-1:0] fifo_cnt  [0:CFG_DEPTH-1];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   fifo_count;
   logic [CFG_W-1:0] cur_cfg;
   logic [CNT_W-1:0] remaining;
   logic [OUT_LAT:1] valid_pipe;

   logic cfg_ready;
   logic in_ready;
   logic fifo_empty;
   logic push;
   logic wr;
   logic pop;
   logic launch;
   logic last;

   assign fifo_empty = (fifo_count == '0);
   assign cfg_ready  = !rst && (fifo_count < DEPTH_C);
   assign push       = bus.cfg_valid && cfg_ready;
   // Zero-length configs complete the handshake but never occupy a slot.
   assign wr         = push && (bus.cfg_count != '0);
   assign launch     = bus.in_valid && in_ready;
   assign last       = (remaining == CNT_W'(1));
   assign pop        = !fifo_empty && ((state == IDLE) || (launch && last));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = RUN;
         RUN:     if (launch && last && fifo_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == RUN) && !rst;
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         fifo_data[wr_ptr] <= bus.cfg_data;
         fifo_cnt[wr_ptr]  <= bus.cfg_count;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         cur_cfg    <= '0;
         remaining  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
         // cur_cfg only changes on a pop, so idle settings stay put.
         if (pop) begin
            cur_cfg   <= fifo_data[rd_ptr];
            remaining <= fifo_cnt[rd_ptr];
         end else if (launch) begin
            remaining <= remaining - 1'b1;
         end
      end
   end

   // Stage k samples its slice STAGE_LAT*k cycles after launch; each stage
   // keeps only its own slice of the delayed launch config.
   assign bus.switch_set[0] = cur_cfg[SW_W-1:0];

   for (genvar k = 1; k < N_STAGES; k++) begin : g_skew
      localparam int D = STAGE_LAT * k;
      logic [SW_W-1:0] dly [1:D];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int d = 1; d <= D; d++) dly[d] <= '0;
         end else begin
            dly[1] <= cur_cfg[SW_W*k +: SW_W];
            for (int d = 2; d <= D; d++) dly[d] <= dly[d-1];
         end
      end

      assign bus.switch_set[k] = dly[D];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_pipe <= '0;
      end else begin
         valid_pipe[1] <= launch;
         for (int i = 2; i <= OUT_LAT; i++) valid_pipe[i] <= valid_pipe[i-1];
      end
   end

   assign bus.cfg_ready = cfg_ready;
   assign bus.in_ready  = in_ready;
   assign bus.net_valid = launch;
   assign bus.out_valid = valid_pipe[OUT_LAT];
   assign bus.busy      = (state == RUN) || (|valid_pipe);

`ifdef BENES_CFG_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_words <= '0;
         stat_cfgs  <= '0;
      end else begin
         if (launch) stat_words <= stat_words + 32'd1;
         if (launch && last) stat_cfgs <= stat_cfgs + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_benes_cfg_scheduler.sv
// Bench for benes_cfg_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a queue-level model of the scheduler.
module tb_benes_cfg_scheduler;
   localparam int N_STAGES = 5;
   localparam int SW_W     = 4;
   localparam int CNT_W    = 16;
   localparam int CFG_W    = N_STAGES * SW_W;
   localparam int OUT_LAT  = 9;
   localparam int DEPTH    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   benes_cfg_scheduler_if #(.N_STAGES(N_STAGES), .SW_W(SW_W), .CNT_W(CNT_W)) bus ();

`ifdef BENES_CFG_STATS_EN
   logic [31:0] stat_words;
   logic [15:0] stat_cfgs;
`endif

   benes_cfg_scheduler #(
      .N_STAGES(N_STAGES), .SW_W(SW_W), .STAGE_LAT(2), .OUT_LAT(OUT_LAT),
      .CFG_DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef BENES_CFG_STATS_EN
      ,
      .stat_words(stat_words),
      .stat_cfgs(stat_cfgs)
`endif
   );

   // Model state: pending configs, active config, and the recent history of
   // launch configs / launch events that the skew and valid taps expose.
   logic [CFG_W-1:0] mq_data [$];
   logic [CNT_W-1:0] mq_cnt  [$];
   bit               m_run = 1'b0;
   logic [CFG_W-1:0] m_cur = '0;
   int               m_rem = 0;
   logic [CFG_W-1:0] hist [1:8];
   bit               lh [1:OUT_LAT];
   int               m_words = 0;
   int               m_cfgs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit e_cfg_ready();
      return !rst && (mq_data.size() < DEPTH);
   endfunction

   function automatic bit e_in_ready();
      return m_run && !rst;
   endfunction

   function automatic bit e_launch();
      return bus.in_valid && e_in_ready();
   endfunction

   function automatic logic [SW_W-1:0] e_sw(input int k);
      logic [CFG_W-1:0] c;
      c = (k == 0) ? m_cur : hist[2*k];
      return c[SW_W*k +: SW_W];
   endfunction

   function automatic bit e_busy();
      bit b;
      b = m_run;
      for (int i = 1; i <= OUT_LAT; i++) b = b | lh[i];
      return b;
   endfunction

   task automatic model_step();
      bit l;
      bit acc;
      l   = e_launch();
      acc = bus.cfg_valid && e_cfg_ready();
      if (rst) begin
         mq_data.delete();
         mq_cnt.delete();
         m_run = 1'b0;
         m_cur = '0;
         m_rem = 0;
         for (int i = 1; i <= 8; i++) hist[i] = '0;
         for (int i = 1; i <= OUT_LAT; i++) lh[i] = 1'b0;
         m_words = 0;
         m_cfgs  = 0;
         return;
      end
      for (int i = OUT_LAT; i > 1; i--) lh[i] = lh[i-1];
      lh[1] = l;
      for (int i = 8; i > 1; i--) hist[i] = hist[i-1];
      hist[1] = m_cur;
      if (l) m_words++;
      if (!m_run) begin
         if (mq_data.size() > 0) begin
            m_cur = mq_data.pop_front();
            m_rem = int'(mq_cnt.pop_front());
            m_run = 1'b1;
         end
      end else if (l) begin
         m_rem--;
         if (m_rem == 0) begin
            m_cfgs++;
            if (mq_data.size() > 0) begin
               m_cur = mq_data.pop_front();
               m_rem = int'(mq_cnt.pop_front());
            end else begin
               m_run = 1'b0;
            end
         end
      end
      if (acc && (bus.cfg_count != '0)) begin
         mq_data.push_back(bus.cfg_data);
         mq_cnt.push_back(bus.cfg_count);
      end
   endtask

   initial begin
      for (int i = 1; i <= 8; i++) hist[i] = '0;
      for (int i = 1; i <= OUT_LAT; i++) lh[i] = 1'b0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("cfg_ready", bus.cfg_ready, e_cfg_ready());
         chk("in_ready", bus.in_ready, e_in_ready());
         chk("net_valid", bus.net_valid, e_launch());
         for (int k = 0; k < N_STAGES; k++) chk($sformatf("switch_set%0d", k), bus.switch_set[k], e_sw(k));
         chk("out_valid", bus.out_valid, lh[OUT_LAT]);
         chk("busy", bus.busy, e_busy());
`ifdef BENES_CFG_STATS_EN
         chk("stat_words", stat_words, m_words);
         chk("stat_cfgs", stat_cfgs, 32'(m_cfgs[15:0]));
`endif
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = '0;
      bus.cfg_count = '0;
      bus.in_valid  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (!bus.busy) break;
         nxt();
         n++;
         if (n >= 200) break;
      end
      chk(name, bus.busy, 0);
      nxt();
   endtask

   initial begin
      int n;
      logic [4:0] pat;
      idle_in();
      rst = 1'b1;
      nxt();
      @(negedge clk);
      chk("rst_cfg_ready", bus.cfg_ready, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_switch4", bus.switch_set[4], 0);
      nxt();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cfg_ready", bus.cfg_ready, 1);
      nxt();

      // Single config, count 3, 0x12345.
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 20'h12345;
      bus.cfg_count = 16'd3;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      chk("t1_push_ready", bus.cfg_ready, 1);
      chk("t1_in_ready_c0", bus.in_ready, 0);
      nxt();
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      chk("t1_in_ready_c1", bus.in_ready, 0);
      nxt();
      for (int d = 0; d <= 12; d++) begin
         @(negedge clk);
         chk("t1_net_valid", bus.net_valid, (d < 3));
         chk("t1_out_valid", bus.out_valid, (d >= 9 && d <= 11));
         if (d == 0) chk("t1_sw0", bus.switch_set[0], 5);
         if (d == 7) chk("t1_sw4_before", bus.switch_set[4], 0);
         if (d == 8) chk("t1_sw4", bus.switch_set[4], 1);
         if (d == 12) chk("t1_busy_end", bus.busy, 0);
         nxt();
      end

      // Back-to-back configs A then B, no bubble.
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 20'h11111;
      bus.cfg_count = 16'd2;
      bus.in_valid  = 1'b1;
      nxt();
      bus.cfg_data  = 20'h22222;
      nxt();
      bus.cfg_valid = 1'b0;
      for (int d = 0; d <= 10; d++) begin
         @(negedge clk);
         chk("t2_net_valid", bus.net_valid, (d < 4));
         for (int k = 0; k < N_STAGES; k++) begin
            if (d == 2*k + 1) chk($sformatf("t2_sw%0d_old", k), bus.switch_set[k], 1);
            if (d == 2*k + 2) chk($sformatf("t2_sw%0d_new", k), bus.switch_set[k], 2);
         end
         nxt();
      end
      wait_idle("t2_drain");

      // Fill the FIFO with no launches; sixth push waits for a completed config.
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = 20'($urandom);
         bus.cfg_count = 16'd2;
         @(negedge clk);
         chk("t3_accept", bus.cfg_ready, 1);
         nxt();
      end
      bus.cfg_data = 20'hABCDE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_full", bus.cfg_ready, 0);
         chk("t3_running", bus.in_ready, 1);
         nxt();
      end
      bus.in_valid = 1'b1;
      for (int d = 0; d < 3; d++) begin
         @(negedge clk);
         chk("t3_ready_after_done", bus.cfg_ready, (d == 2));
         nxt();
      end
      bus.cfg_valid = 1'b0;
      wait_idle("t3_drain");

      // Zero-count push in IDLE.
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 20'h54321;
      bus.cfg_count = 16'd0;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      chk("t4_accept", bus.cfg_ready, 1);
      nxt();
      bus.cfg_valid = 1'b0;
      for (int d = 0; d < 5; d++) begin
         @(negedge clk);
         chk("t4_in_ready", bus.in_ready, 0);
         chk("t4_net_valid", bus.net_valid, 0);
         nxt();
      end

      // Reset in the middle of a 5-word config with another config queued.
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 20'h9ABCD;
      bus.cfg_count = 16'd5;
      bus.in_valid  = 1'b1;
      nxt();
      bus.cfg_data  = 20'h13579;
      bus.cfg_count = 16'd4;
      nxt();
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      chk("t5_launch0", bus.net_valid, 1);
      nxt();
      @(negedge clk);
      chk("t5_launch1", bus.net_valid, 1);
      nxt();
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_in_ready", bus.in_ready, 0);
      chk("t5_rst_cfg_ready", bus.cfg_ready, 0);
      nxt();
      rst = 1'b0;
      for (int d = 0; d < 10; d++) begin
         @(negedge clk);
         for (int k = 0; k < N_STAGES; k++) chk($sformatf("t5_sw%0d", k), bus.switch_set[k], 0);
         chk("t5_in_ready", bus.in_ready, 0);
         chk("t5_out_valid", bus.out_valid, 0);
         nxt();
      end

      // Bubbled launches 1,0,1,0,1.
      pat = 5'b10101;
      bus.in_valid  = 1'b0;
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 20'h2468A;
      bus.cfg_count = 16'd3;
      nxt();
      bus.cfg_valid = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         nxt();
         n++;
         if (n >= 20) break;
      end
      chk("t6_in_ready_wait", bus.in_ready, 1);
      nxt();
      for (int d = 0; d <= 13; d++) begin
         bus.in_valid = (d < 5) ? pat[d] : 1'b0;
         @(negedge clk);
         chk("t6_net_valid", bus.net_valid, (d < 5) ? pat[d] : 1'b0);
         chk("t6_out_valid", bus.out_valid, (d >= 9) ? pat[d-9] : 1'b0);
         nxt();
      end
      wait_idle("t6_drain");

      // Randomized traffic in three pressure phases, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         bus.cfg_valid = ($urandom_range(0, 3) < ((c < 1000) ? 1 : 3));
         bus.cfg_data  = 20'($urandom);
         bus.cfg_count = 16'($urandom_range(0, 4));
         bus.in_valid  = ($urandom_range(0, 3) < ((c >= 2000) ? 2 : 3));
         rst           = ($urandom_range(0, 299) == 0);
         nxt();
      end
      rst = 1'b0;
      idle_in();
      wait_idle("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
